// File: rtl/univ_range_counter.sv
// Range counter with programmable bounds, step and terminal-count mode.
// Modes: wrap, saturate, bounce, one-shot.
module univ_range_counter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         syn_clr,
  input  logic         load,
  input  logic         en,
  input  logic         up,
  input  logic [N-1:0] d,
  input  logic [N-1:0] step,
  input  logic [N-1:0] lo,
  input  logic [N-1:0] hi,
  input  logic [1:0]   mode,
  output logic [N-1:0] q,
  output logic         max_tick,
  output logic         min_tick,
  output logic         dir,
  output logic         evt,
  output logic         done,
  output logic         cfg_err
);

  typedef enum logic [1:0] {
    M_WRAP    = 2'b00,
    M_SAT     = 2'b01,
    M_BOUNCE  = 2'b10,
    M_ONESHOT = 2'b11
  } mode_t;

  logic [N-1:0] r_q;
  logic         r_dir;
  logic         r_evt;
  logic         r_done;

  logic [N-1:0] w_q_nxt;
  logic         w_dir_nxt;
  logic         w_evt_nxt;
  logic         w_done_nxt;

  mode_t        w_mode;
  logic         w_bounce;
  logic         w_cfg_err;
  logic         w_cnt_en;
  logic         w_eff_up;
  logic         w_oor;
  logic [N:0]   w_sum;
  logic [N:0]   w_lo_step;
  logic [N-1:0] w_diff;
  logic         w_ovr_up;
  logic         w_ext_up;
  logic         w_ovr_dn;
  logic         w_ext_dn;
  logic         w_ovr;
  logic         w_ext;
  logic [N-1:0] w_bnd;
  logic [N-1:0] w_clamp;

  assign w_mode    = mode_t'(mode);
  assign w_bounce  = (w_mode == M_BOUNCE);
  assign w_cfg_err = (lo > hi);
  assign w_cnt_en  = en && !w_cfg_err && !r_done;
  assign w_eff_up  = w_bounce ? r_dir : up;
  assign w_oor     = (r_q > hi) || (r_q < lo);

  // One extra bit keeps the bound comparisons free of wrap-around.
  assign w_sum     = {1'b0, r_q} + {1'b0, step};
  assign w_lo_step = {1'b0, lo} + {1'b0, step};
  assign w_diff    = r_q - step;
  assign w_ovr_up  = (w_sum > {1'b0, hi});
  assign w_ext_up  = (w_sum == {1'b0, hi});
  assign w_ovr_dn  = ({1'b0, r_q} < w_lo_step);
  assign w_ext_dn  = ({1'b0, r_q} == w_lo_step);
  assign w_ovr     = w_eff_up ? w_ovr_up : w_ovr_dn;
  assign w_ext     = w_eff_up ? w_ext_up : w_ext_dn;
  assign w_bnd     = w_eff_up ? hi : lo;

  assign w_clamp = (d < lo) ? lo :
                   (d > hi) ? hi : d;

  always_comb begin
    w_q_nxt    = r_q;
    w_dir_nxt  = r_dir;
    w_done_nxt = r_done;
    w_evt_nxt  = 1'b0;
    if (syn_clr) begin
      w_q_nxt    = lo;
      w_dir_nxt  = up;
      w_done_nxt = 1'b0;
    end else if (load && !w_cfg_err) begin
      w_q_nxt    = w_clamp;
      w_dir_nxt  = up;
      w_done_nxt = 1'b0;
    end else if (w_cnt_en) begin
      if (w_oor) begin
        w_q_nxt   = w_eff_up ? lo : hi;
        w_evt_nxt = 1'b1;
        if (!w_bounce) w_dir_nxt = up;
      end else if (step != '0) begin
        if (!w_bounce) w_dir_nxt = up;
        if (!(w_ovr || w_ext)) begin
          w_q_nxt = w_eff_up ? w_sum[N-1:0] : w_diff;
        end else begin
          w_q_nxt = w_bnd;
          unique case (w_mode)
            M_WRAP: begin
              if (w_ovr) begin
                w_q_nxt   = w_eff_up ? lo : hi;
                w_evt_nxt = 1'b1;
              end
            end
            M_SAT: begin
              w_evt_nxt = (r_q != w_bnd);
            end
            M_BOUNCE: begin
              w_dir_nxt = ~r_dir;
              w_evt_nxt = 1'b1;
            end
            M_ONESHOT: begin
              w_done_nxt = 1'b1;
              w_evt_nxt  = 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q    <= '0;
      r_dir  <= 1'b1;
      r_evt  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_dir  <= w_dir_nxt;
      r_evt  <= w_evt_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign q        = r_q;
  assign dir      = r_dir;
  assign evt      = r_evt;
  assign done     = r_done;
  assign cfg_err  = w_cfg_err;
  assign max_tick = (r_q == hi);
  assign min_tick = (r_q == lo);

endmodule

// File: doc/univ_range_counter.md
Name: univ_range_counter

Overview:
- Parametrised successor to the team's universal binary counter.
- Adds programmable lower and upper bounds, a programmable step, and four terminal-count modes: wrap, saturate, bounce and one-shot.
- Used as a general timebase, address generator or sweep generator wherever the plain up/down counter is too rigid.
- Keeps the familiar control set: syn_clr, load, en, up, d, max_tick, min_tick, q.

Parameters:
- N, 8, counter, bound and step width in bits (N >= 2).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- syn_clr  in  1  synchronous clear: q <= lo
- load  in  1  synchronous load of d, clamped to the range
- en  in  1  count enable
- up  in  1  count direction (1 = up); in bounce mode it is sampled only on load/syn_clr
- d  in  N  load value
- step  in  N  increment per enabled cycle; 0 means q holds
- lo  in  N  lower bound, inclusive
- hi  in  N  upper bound, inclusive
- mode  in  2  00 wrap, 01 saturate, 10 bounce, 11 one-shot
- q  out  N  count value, registered
- max_tick  out  1  combinational, q == hi
- min_tick  out  1  combinational, q == lo
- dir  out  1  registered effective direction (1 = up)
- evt  out  1  registered one-cycle pulse on wrap, bound hit, reversal or out-of-range recovery
- done  out  1  registered; one-shot mode has reached its terminal bound
- cfg_err  out  1  combinational, lo > hi

Behaviour:
- Reset (async, active-high): q = 0, dir = 1, done = 0, evt = 0. Reset is effective immediately at any point, including mid-count.
- Priority each clock edge: syn_clr > load > count.
- syn_clr: q <= lo; dir <= up; done <= 0; evt <= 0. This applies even when cfg_err = 1.
- load: q <= clamp(d, lo, hi); dir <= up; done <= 0; evt <= 0. Load is ignored while cfg_err = 1.
- Count occurs when en = 1, cfg_err = 0, and done = 0.
  - Effective direction is dir in bounce mode and up in all other modes.
  - In non-bounce modes, dir <= up every counting cycle.
- Arithmetic: use N+1-bit sums and differences.
  - Overshoot up: q + step > hi.
  - Overshoot down: q < lo + step, evaluated as q - step < lo without underflow.
  - A landing exactly on a bound is not an overshoot.
- Out-of-range recovery: if q > hi or q < lo when counting (e.g. bounds changed mid-run), then q <= lo (direction up) or hi (direction down), evt <= 1. This overrides the mode rules for that cycle.
- Overshoot actions by mode:
  - Wrap: up goes to lo, down goes to hi; no remainder carry; evt pulse.
  - Saturate: up goes to hi, down goes to lo. evt pulses only on the cycle q first reaches the bound, not while parked there.
  - Bounce: q <= bound (hi or lo), dir toggles, evt pulse. After that the counter runs away from the bound.
  - One-shot: q <= bound, done <= 1, evt pulse. Counting then freezes until syn_clr or load.
- Exact landing on the bound:
  - Wrap: q <= bound, no evt. The next count wraps.
  - Saturate / one-shot: q <= bound, evt <= 1, done <= 1 for one-shot.
  - Bounce: q <= bound, dir toggles, evt <= 1.
- lo == hi: q pins to lo every counting cycle. Wrap pulses evt every cycle; bounce toggles dir every cycle.
- step = 0: q holds, no evt, dir unchanged.
- evt defaults to 0 on any cycle without a qualifying event, including en = 0.
- Changing mode mid-run takes effect on the next counting edge. done stays set until syn_clr or load.

Test Plan:
- N=4, lo=3, hi=9, step=2, mode=wrap, up=1, syn_clr, en → q: 3,5,7,9,3,5. evt=1 only on the cycle after 9→3. max_tick=1 while q=9.
- Same config with mode=saturate → q: 3,5,7,9,9,9. evt pulses once, on the 7→9 edge. With up=0 from 9 → 7,5,3,3 and min_tick=1 at 3.
- mode=bounce, lo=2, hi=6, step=3, load d=2 with up=1 → q: 2,5,6,3,2,5. dir goes 1,1,0,0,1. evt on the arrivals at 6 and at 2.
- mode=one-shot, lo=0, hi=5, step=2 → q: 0,2,4,5. done=1 and q stays 5 with en held high. Load d=15 → q=5 (clamped), done=0.
- Set lo=8, hi=4 → cfg_err=1; en and load are ignored and q holds. syn_clr → q=8. Restore hi=12 and count up by 1 from q=8 → 9.
- Assert reset mid-count at q=7 between clock edges → q=0, dir=1, done=0 immediately. With lo=3 and en=1 the next edge gives q=3 and evt=1 (out-of-range recovery).
